// File: rtl/ecc_key_fetch.sv
`default_nettype none
// ============================================================================
// Module   : ecc_key_fetch
// Summary  : Reads one private key slot from the tag ROM and streams it word
//            by word into the ECC controller key shift register.
//            Optional CRC-16 slot check compiled in with ECC_KEY_CRC_EN.
// Revision : 1.0
// ============================================================================
module ecc_key_fetch #(
  parameter int ADDR_W      = 8,
  parameter int KEY_WORDS   = 11,
  parameter int ROM_LAT     = 1,
  parameter int KEY_BASE    = 8'h20,
  parameter int SLOT_STRIDE = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_time_up,
  input  logic              i_load_req,
  input  logic [1:0]        i_key_sel,
  output logic [ADDR_W-1:0] o_rom_addr,
  output logic              o_rom_rd,
  input  logic [15:0]       i_rom_data,
  output logic [15:0]       o_data_rom_16bits,
  output logic              o_key_shift,
  output logic              o_done_key,
  output logic              o_busy,
  output logic              o_key_err
);

`ifdef ECC_KEY_CRC_EN
  localparam int C_NUM_READS = KEY_WORDS + 1;
`else
  localparam int C_NUM_READS = KEY_WORDS;
`endif
  localparam int                C_IDX_W    = $clog2(C_NUM_READS + 1);
  localparam logic [ADDR_W-1:0] C_BASE     = ADDR_W'(KEY_BASE);
  localparam logic [ADDR_W-1:0] C_STRIDE   = ADDR_W'(SLOT_STRIDE);
  localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(C_NUM_READS - 1);
  localparam logic [C_IDX_W-1:0] C_KEY_IDX  = C_IDX_W'(KEY_WORDS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
`ifdef ECC_KEY_CRC_EN
    S_CHECK = 3'd3,
`endif
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_sel;
  logic [C_IDX_W-1:0]  r_idx;
  logic [ROM_LAT-1:0]  r_pv;
  logic [C_IDX_W-1:0]  r_pidx [ROM_LAT];
  logic [15:0]         r_data;
  logic                r_key_shift;
  logic                w_start;
  logic                w_issue;
  logic                w_ret_v;
  logic                w_ret_key;
  logic                w_pipe_busy;
  logic [C_IDX_W-1:0]  w_ret_idx;
  logic                w_crc_ok;

  assign w_start   = (r_state == S_IDLE) && i_load_req && !i_time_up;
  assign w_issue   = (r_state == S_FETCH) && !i_time_up;
  assign w_ret_v   = r_pv[ROM_LAT-1];
  assign w_ret_idx = r_pidx[ROM_LAT-1];
  assign w_ret_key = w_ret_v && (w_ret_idx < C_KEY_IDX);

  // A CRC word sitting in the last stage is captured this cycle, so it does
  // not hold DRAIN; every key word still in flight does.
  always_comb begin
    w_pipe_busy = 1'b0;
    for (int s = 0; s < ROM_LAT; s++) begin
      if (r_pv[s] && ((s != ROM_LAT - 1) || (r_pidx[s] < C_KEY_IDX))) begin
        w_pipe_busy = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    o_rom_rd   = w_issue;
    o_busy     = (r_state != S_IDLE);
    o_done_key = (r_state == S_DONE);
    o_rom_addr = '0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next = S_FETCH;
        end
      end
      S_FETCH: begin
        o_rom_addr = C_BASE + ADDR_W'(r_sel) * C_STRIDE + ADDR_W'(r_idx);
        if (r_idx == C_LAST_IDX) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!w_pipe_busy) begin
`ifdef ECC_KEY_CRC_EN
          w_next = S_CHECK;
`else
          w_next = S_DONE;
`endif
        end
      end
`ifdef ECC_KEY_CRC_EN
      S_CHECK: begin
        w_next = w_crc_ok ? S_DONE : S_IDLE;
      end
`endif
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (i_time_up) begin
      w_next = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel <= 2'd0;
      r_idx <= '0;
    end else if (w_start) begin
      r_sel <= i_key_sel;
      r_idx <= '0;
    end else if (w_issue) begin
      r_idx <= r_idx + C_IDX_W'(1);
    end
  end

  // Valid/index shadow of the ROM pipeline; stage ROM_LAT-1 lines up with i_rom_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pv <= '0;
      for (int s = 0; s < ROM_LAT; s++) begin
        r_pidx[s] <= '0;
      end
    end else if (i_time_up) begin
      r_pv <= '0;
    end else begin
      r_pv[0]   <= w_issue;
      r_pidx[0] <= r_idx;
      for (int s = 1; s < ROM_LAT; s++) begin
        r_pv[s]   <= r_pv[s-1];
        r_pidx[s] <= r_pidx[s-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_shift <= 1'b0;
      r_data      <= 16'h0000;
    end else begin
      r_key_shift <= w_ret_key && !i_time_up;
      if (w_ret_key && !i_time_up) begin
        r_data <= i_rom_data;
      end
    end
  end

  assign o_key_shift       = r_key_shift;
  assign o_data_rom_16bits = r_data;

`ifdef ECC_KEY_CRC_EN
  // CRC-16-CCITT, MSB first, one full word per call.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [15:0] d);
    logic [15:0] c;
    c = crc;
    for (int b = 15; b >= 0; b--) begin
      if (c[15] ^ d[b]) begin
        c = {c[14:0], 1'b0} ^ 16'h1021;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

  logic [15:0] r_crc;
  logic [15:0] r_crc_word;
  logic        r_key_err;

  assign w_crc_ok = (r_crc == r_crc_word);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc      <= 16'hFFFF;
      r_crc_word <= 16'h0000;
      r_key_err  <= 1'b0;
    end else begin
      if (w_start) begin
        r_crc     <= 16'hFFFF;
        r_key_err <= 1'b0;
      end else if (w_ret_key && !i_time_up) begin
        r_crc <= crc16_step(r_crc, i_rom_data);
      end
      if (w_ret_v && !w_ret_key && !i_time_up) begin
        r_crc_word <= i_rom_data;
      end
      if ((r_state == S_CHECK) && !i_time_up && !w_crc_ok) begin
        r_key_err <= 1'b1;
      end
    end
  end

  assign o_key_err = r_key_err;
`else
  assign w_crc_ok  = 1'b1;
  assign o_key_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/ecc_key_fetch.md
# ecc_key_fetch

Upstream feeder for the ECC controller: on request, reads one 176-bit private key (eleven 16-bit words) from the tag ROM and streams it word-by-word into the controller's key shift register. It drives `i_key_shift_cu`, `i_data_rom_16bits` and `i_done_key` of the ECC controller. It also owns the ROM read port during key fetch. An optional CRC check rejects corrupted key slots before the controller sees a done.

## Interface

**Parameters**
- `ADDR_W`, 8: ROM word-address width.
- `KEY_WORDS`, 11: 16-bit words per key; word 0 ends up in key bits [175:160].
- `ROM_LAT`, 1: ROM read latency in cycles, from `o_rom_rd` to valid `i_rom_data`; legal range 1..3.
- `KEY_BASE`, 8'h20: word address of key slot 0.
- `SLOT_STRIDE`, 16: words between consecutive key slots.

**Ports**
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `i_time_up`, input, 1: synchronous abort; same signal the ECC controller receives.
- `i_load_req`, input, 1: single-cycle request to fetch a key.
- `i_key_sel`, input, 2: key slot, sampled with `i_load_req`.
- `o_rom_addr`, output, ADDR_W: ROM word address.
- `o_rom_rd`, output, 1: ROM read strobe, one word per cycle.
- `i_rom_data`, input, 16: ROM read data, valid ROM_LAT cycles after the strobe.
- `o_data_rom_16bits`, output, 16: key word to the controller (registered).
- `o_key_shift`, output, 1: shift strobe; `o_data_rom_16bits` is valid while it is high.
- `o_done_key`, output, 1: one-cycle pulse after the last key word has been shifted.
- `o_busy`, output, 1: high in every state except IDLE.
- `o_key_err`, output, 1: sticky CRC mismatch flag (only when CRC is compiled in).

## Operation

- **States:** IDLE, FETCH, DRAIN, CHECK (only with CRC), DONE.
- **IDLE:** `i_load_req`=1 latches `i_key_sel`, clears the read index, clears `o_key_err`, and moves to FETCH.
- **FETCH:** `o_rom_rd`=1 each cycle with `o_rom_addr` = KEY_BASE + sel·SLOT_STRIDE + idx, truncated mod 2^ADDR_W (wrap-around permitted).
  - idx runs 0..NW-1, where NW = KEY_WORDS, or KEY_WORDS+1 with CRC.
  - After issuing idx = NW-1, go to DRAIN.
- **Read tracking:** a ROM_LAT-deep valid/index pipeline tracks outstanding reads.
  - When a return is valid and its index < KEY_WORDS, capture `i_rom_data` into `o_data_rom_16bits` and pulse `o_key_shift` the next cycle.
  - A return with index = KEY_WORDS (the CRC word) is captured internally only; no shift pulse.
- **DRAIN:** wait until the pipeline is empty and the last shift has been issued, then go to CHECK (CRC) or DONE.
- **DONE:** `o_done_key`=1 for one cycle, then IDLE.
- **Word ordering:** words are presented in increasing address order, so exactly KEY_WORDS shift pulses occur per successful fetch.
- **`i_load_req` while busy:** ignored, not queued.
- **`i_time_up`:** in any state, next state is IDLE. It clears the valid pipeline and `o_rom_rd`; no further `o_key_shift` or `o_done_key` is produced. `o_key_err` keeps its value.
- **`i_time_up` and `i_load_req` in the same cycle:** `i_time_up` wins and the request is dropped.
- **Reset values:** all outputs are 0 and the state is IDLE.

## Timing

With ROM_LAT=1, no CRC, and `i_load_req` high in cycle 0:
- `o_rom_rd` is high in cycles 1–11, addresses base..base+10.
- Data returns in cycles 2–12.
- `o_key_shift` is high in cycles 3–13.
- `o_done_key` pulses in cycle 14.
- `o_busy` is high in cycles 1–14.
- Each extra cycle of ROM_LAT shifts everything after the reads by one cycle.

With CRC enabled:
- `o_rom_rd` is high in cycles 1–12.
- The CRC word returns in cycle 13.
- CHECK occupies cycle 14; `o_done_key` pulses in cycle 15 on a match.

`o_key_shift` is never high in the same cycle as `o_done_key`.

## Configuration

Macro: `ECC_KEY_CRC_EN`.

- **Defined:** one extra word is read after the key (slot word KEY_WORDS).
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB first, 16 bits per cycle) is computed over the KEY_WORDS shifted words.
  - In CHECK, a match goes to DONE.
  - A mismatch sets `o_key_err`=1, goes to IDLE, and produces no `o_done_key`. The downstream controller then waits for `i_time_up`.
- **Not defined:** no CRC word is read, the CHECK state and CRC logic are absent, and `o_key_err` is tied to 0.

## Test plan

- **Basic fetch:** ROM_LAT=1, no CRC, sel=2, ROM[0x40+i]=16'h1000+i, `i_load_req` in cycle 0 → `o_rom_addr` 0x40..0x4A in cycles 1–11, shift pulses in cycles 3–13 with data 0x1000..0x100A, `o_done_key` in cycle 14, assembled key[175:160]=16'h1000.
- **Latency sweep:** ROM_LAT=3 → same data sequence; shifts in cycles 5–15, done in cycle 16, exactly 11 shifts.
- **Abort:** `i_time_up` in cycle 6 → `o_rom_rd`, `o_key_shift`, `o_busy` are 0 from cycle 7 on; no `o_done_key`. A new `i_load_req` in cycle 8 fetches cleanly.
- **Request collisions:**
  - `i_load_req` in cycle 5 during a fetch → ignored; exactly one done pulse.
  - `i_load_req` together with `i_time_up` → no fetch starts.
- **CRC (`ECC_KEY_CRC_EN` defined):**
  - Correct CRC in ROM[base+11] → done in cycle 15, `o_key_err`=0.
  - One bit of word 4 flipped → 11 shifts, `o_key_err`=1, no done. The next good request clears `o_key_err`.
- **Address wrap:** KEY_BASE=8'hF8, sel=0 → addresses 0xF8..0xFF then 0x00..0x02; data is correct.
